reset_sequencer: RTL and testbench

Reset and start-up sequencer downstream of the clock manager. Watches the SRAM DCM lock, debounces it, and restarts the DCM if lock never arrives. It then releases the SRAM-side reset and the main-system reset in order, with each release aligned to a rising edge of the divide-by-10 system clock. On lock loss it re-asserts every reset at once. It runs on the board clock so it keeps operating while the DCM output is invalid.

---
 rtl/falcon_clk_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/falcon_clk_pkg.sv
// falcon_clk_pkg -- shared definitions for the clock-manager reset sequencer.
//   seq_state_e : sequencer state encodings (3 bits; 6 and 7 are unused)
//   SEQ_STATE_W : width of the state encoding
//   CNT_W       : width of the shared sequencer counter
//   DEF_*       : default values for the sequencer timing parameters
package falcon_clk_pkg;

    localparam int SEQ_STATE_W = 3;
    localparam int CNT_W       = 16;

    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_DCM_RESET_CYCLES    = 10;
    localparam int DEF_STAGE_GAP_CYCLES    = 16;

    typedef enum logic [SEQ_STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        DCM_RST   = 3'd1,
        STABLE    = 3'd2,
        WAIT_SYNC = 3'd3,
        SRAM_UP   = 3'd4,
        RUN       = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- generic two-flop synchronizer with asynchronous active-low clear.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low clear (both stages go to 0)
//   d     in  W-bit asynchronous input
//   q     out W-bit synchronized output, two clk cycles behind d
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer -- start-up / lock-loss reset sequencer on the board clock.
// Debounces the SRAM DCM lock, pulses the DCM reset if lock never arrives,
// then releases the SRAM-side reset and the system reset in order, each
// aligned to a rising edge of the divide-by-10 phase reference.
//
// Optional build macro: LOCK_LOSS_COUNT_EN adds the lock_loss_count port and
// its saturating 8-bit counter of lock losses seen in SRAM_UP or RUN.
//
// Ports:
//   input_clk           in  board clock, the only clock
//   global_reset_n      in  asynchronous active-low reset
//   dcm_locked_sram     in  DCM lock (asynchronous)
//   modified_clock_sync in  divide-by-10 phase reference (asynchronous)
//   dcm_reset_sram      out active-high DCM reset request
//   sram_reset_n        out active-low SRAM-clock-domain reset
//   system_reset_n      out active-low main-system reset
//   system_ready        out high only in RUN
//   seq_state           out current state encoding
//   lock_loss_count     out saturating lock-loss count (LOCK_LOSS_COUNT_EN only)
module reset_sequencer
    import falcon_clk_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int DCM_RESET_CYCLES    = DEF_DCM_RESET_CYCLES,
    parameter int STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES
) (
    input  logic                   input_clk,
    input  logic                   global_reset_n,
    input  logic                   dcm_locked_sram,
    input  logic                   modified_clock_sync,
    output logic                   dcm_reset_sram,
    output logic                   sram_reset_n,
    output logic                   system_reset_n,
    output logic                   system_ready,
    output logic [SEQ_STATE_W-1:0] seq_state
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]             lock_loss_count
`endif
);

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCM_LAST     = CNT_W'(DCM_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_SAT      = CNT_W'(STAGE_GAP_CYCLES);

    logic       lock_s;
    logic       sync_s;
    logic       sync_s_d;
    logic       sync_rise_q;
    seq_state_e state;
    seq_state_e nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (input_clk),
        .rst_n (global_reset_n),
        .d     (dcm_locked_sram),
        .q     (lock_s)
    );

    sync_2ff #(.W(1)) u_phase_sync (
        .clk   (input_clk),
        .rst_n (global_reset_n),
        .d     (modified_clock_sync),
        .q     (sync_s)
    );

    // The rising-edge detect is registered: the phase reference then reaches
    // the reset outputs in a fixed 4 cycles (2 sync + 1 detect + 1 output).
    always_ff @(posedge input_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            sync_s_d    <= 1'b0;
            sync_rise_q <= 1'b0;
        end else begin
            sync_s_d    <= sync_s;
            sync_rise_q <= sync_s & ~sync_s_d;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s)                   nxt = STABLE;
                else if (cnt == TIMEOUT_LAST) nxt = DCM_RST;
                else                          cnt_nxt = cnt + 1'b1;
            end
            DCM_RST: begin
                if (cnt == DCM_LAST) nxt = WAIT_LOCK;
                else                 cnt_nxt = cnt + 1'b1;
            end
            STABLE: begin
                if (!lock_s)                 nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) nxt = WAIT_SYNC;
                else                         cnt_nxt = cnt + 1'b1;
            end
            WAIT_SYNC: begin
                if (!lock_s)          nxt = WAIT_LOCK;
                else if (sync_rise_q) nxt = SRAM_UP;
            end
            SRAM_UP: begin
                // lock loss wins over a coincident phase edge
                if (!lock_s)                              nxt = WAIT_LOCK;
                else if (sync_rise_q && cnt >= GAP_LAST)  nxt = RUN;
                else if (cnt < GAP_SAT)                   cnt_nxt = cnt + 1'b1;
            end
            RUN: begin
                if (!lock_s) nxt = WAIT_LOCK;
            end
            default: nxt = WAIT_LOCK;
        endcase
        if (nxt != state) cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and never pass through combinational logic.
    always_ff @(posedge input_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state          <= WAIT_LOCK;
            cnt            <= '0;
            dcm_reset_sram <= 1'b0;
            sram_reset_n   <= 1'b0;
            system_reset_n <= 1'b0;
            system_ready   <= 1'b0;
        end else begin
            state          <= nxt;
            cnt            <= cnt_nxt;
            dcm_reset_sram <= (nxt == DCM_RST);
            sram_reset_n   <= (nxt == SRAM_UP) || (nxt == RUN);
            system_reset_n <= (nxt == RUN);
            system_ready   <= (nxt == RUN);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    // Only losses after the SRAM reset was released are counted.
    always_ff @(posedge input_clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            lock_loss_count <= 8'd0;
        end else if (!lock_s && (state == SRAM_UP || state == RUN)
                     && lock_loss_count != 8'hFF) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`endif

    assign seq_state = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer -- directed self-checking bench for reset_sequencer.
// Small timing parameters; the phase reference toggles every 5 cycles.
// Cycle numbering: cyc counts rising edges after global reset release;
// inputs change 1 time unit after edge cyc, outputs are checked there too.
// Set LOCK_LOSS_COUNT_EN to also exercise lock_loss_count.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       global_reset_n;
    logic       lock;
    logic       sync;
    logic       dcm_rst;
    logic       sram_rst_n;
    logic       sys_rst_n;
    logic       ready;
    logic [2:0] st;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] llc;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (100),
        .DCM_RESET_CYCLES    (10),
        .STAGE_GAP_CYCLES    (4)
    ) dut (
        .input_clk           (clk),
        .global_reset_n      (global_reset_n),
        .dcm_locked_sram     (lock),
        .modified_clock_sync (sync),
        .dcm_reset_sram      (dcm_rst),
        .sram_reset_n        (sram_rst_n),
        .system_reset_n      (sys_rst_n),
        .system_ready        (ready),
        .seq_state           (st)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count     (llc)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] s, input logic dcm,
                            input logic sr, input logic sy);
        chk({tag, ".state"}, 16'(st), 16'(s));
        chk({tag, ".dcm"}, 16'(dcm_rst), 16'(dcm));
        chk({tag, ".sram_n"}, 16'(sram_rst_n), 16'(sr));
        chk({tag, ".sys_n"}, 16'(sys_rst_n), 16'(sy));
        chk({tag, ".ready"}, 16'(ready), 16'(sy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sync = ((cyc / 5) % 2) == 1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        global_reset_n = 1'b0;
        lock = 1'b0;
        sync = 1'b0;
        #12;
        chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("reset.llc", 16'(llc), 16'd0);
`endif
        step();
        step();
        global_reset_n = 1'b1;
        cyc  = 0;
        sync = 1'b0;

        // Normal bring-up: lock at 5, STABLE at 8, WAIT_SYNC at 16,
        // phase rises at 15 -> SRAM_UP at 19, next rise 25 -> RUN at 29.
        run_to(5);  lock = 1'b1;
        run_to(7);  chk("up.wait_lock", 16'(st), 16'd0);
        run_to(8);  chk("up.stable", 16'(st), 16'd2);
        run_to(15); chk("up.stable_end", 16'(st), 16'd2);
        run_to(16); chk("up.wait_sync", 16'(st), 16'd3);
        run_to(18); chk_outs("up.pre_sram", 3'd3, 1'b0, 1'b0, 1'b0);
        run_to(19); chk_outs("up.sram", 3'd4, 1'b0, 1'b1, 1'b0);
        run_to(28); chk_outs("up.gap", 3'd4, 1'b0, 1'b1, 1'b0);
        run_to(29); chk_outs("up.run", 3'd5, 1'b0, 1'b1, 1'b1);

        // Lock loss in RUN: resets asserted 3 cycles later.
        run_to(40); lock = 1'b0;
        run_to(42); chk_outs("loss.pre", 3'd5, 1'b0, 1'b1, 1'b1);
        run_to(43); chk_outs("loss.post", 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("loss.llc", 16'(llc), 16'd1);
`endif

        // Lock held low: 100-cycle timeout then 10-cycle DCM reset, repeating.
        run_to(142); chk("to.pre", 16'(dcm_rst), 16'd0);
        run_to(143); chk_outs("to.dcm", 3'd1, 1'b1, 1'b0, 1'b0);
        run_to(152); chk("to.dcm_last", 16'(dcm_rst), 16'd1);
        run_to(153); chk_outs("to.dcm_end", 3'd0, 1'b0, 1'b0, 1'b0);
        run_to(252); chk("to2.pre", 16'(dcm_rst), 16'd0);
        run_to(253); chk("to2.dcm", 16'(dcm_rst), 16'd1);
        run_to(262); chk("to2.dcm_last", 16'(dcm_rst), 16'd1);
        run_to(263); chk("to2.dcm_end", 16'(dcm_rst), 16'd0);

        // One-cycle lock glitch while STABLE cnt=5 restarts the stability count.
        run_to(270); lock = 1'b1;
        run_to(276); lock = 1'b0;
        step();      lock = 1'b1;
        run_to(278); chk("gl.stable", 16'(st), 16'd2);
        run_to(279); chk("gl.drop", 16'(st), 16'd0);
        run_to(280); chk("gl.restable", 16'(st), 16'd2);
        run_to(287); chk("gl.stable_end", 16'(st), 16'd2);
        run_to(288); chk_outs("gl.wait_sync", 3'd3, 1'b0, 1'b0, 1'b0);
        run_to(289); chk_outs("gl.sram", 3'd4, 1'b0, 1'b1, 1'b0);

        // Asynchronous global reset in SRAM_UP, then a restart from WAIT_LOCK.
        run_to(291);
        #2 global_reset_n = 1'b0;
        #1 chk_outs("grst.async", 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("grst.llc", 16'(llc), 16'd0);
`endif
        run_to(293); global_reset_n = 1'b1;
        run_to(295); chk("grst.wait_lock", 16'(st), 16'd0);
        run_to(296); chk("grst.stable", 16'(st), 16'd2);
        run_to(304); chk("grst.wait_sync", 16'(st), 16'd3);
        run_to(308); chk_outs("grst.pre_sram", 3'd3, 1'b0, 1'b0, 1'b0);
        run_to(309); chk_outs("grst.sram", 3'd4, 1'b0, 1'b1, 1'b0);

        // Lock loss coincident with the qualifying phase edge: loss wins.
        run_to(316); lock = 1'b0;
        run_to(318); chk_outs("co.pre", 3'd4, 1'b0, 1'b1, 1'b0);
        run_to(319); chk_outs("co.post", 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef LOCK_LOSS_COUNT_EN
        chk("co.llc", 16'(llc), 16'd1);
`endif
        run_to(330); chk("co.sys_low", 16'(sys_rst_n), 16'd0);

`ifdef LOCK_LOSS_COUNT_EN
        // 300 further losses from SRAM_UP/RUN saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            int n;
            lock = 1'b1;
            n = 0;
            while (st != 3'd4 && st != 3'd5 && n < 200) begin
                step();
                n++;
            end
            chk("sat.reach_up", 16'(sram_rst_n), 16'd1);
            lock = 1'b0;
            run_to(cyc + 4);
            if (i == 0) chk("sat.first", 16'(llc), 16'd2);
        end
        chk("sat.llc", 16'(llc), 16'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
